// File: rtl/sram_arbiter.sv
// Two-master arbiter for the shared async SRAM: the CPU (stalled via RDY) and a DMA master.
// Optional macro ARB_ROUND_ROBIN_EN swaps fixed priority + starvation override for round robin.
module sram_arbiter #(
    parameter int WAIT_STATES  = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rdy,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    output logic [7:0]  dma_rdata,
    output logic        dma_ack,
    output logic [15:0] sram_addr,
    output logic [7:0]  sram_dout,
    input  logic [7:0]  sram_din,
    output logic        sram_oe,
    output logic        sram_we
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;
    localparam logic       OWN_CPU   = 1'b0;
    localparam logic       OWN_DMA   = 1'b1;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    logic [1:0]  state_q, state_d;
    logic        owner_q, owner_d;
    logic [15:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [7:0]  cpu_rdata_q, cpu_rdata_d;
    logic [7:0]  dma_rdata_q, dma_rdata_d;
    logic        grant_dma;
    logic        in_idle, in_access, in_done;

    assign in_idle   = (state_q == ST_IDLE);
    assign in_access = (state_q == ST_ACCESS);
    assign in_done   = (state_q == ST_DONE);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_owner_q, last_owner_d;

    // On a tie, whoever was not served last wins.
    always_comb begin
        grant_dma    = dma_req & (~cpu_req | (last_owner_q == OWN_CPU));
        last_owner_d = last_owner_q;
        if (in_idle && (cpu_req || dma_req)) begin
            last_owner_d = grant_dma;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner_q <= OWN_DMA;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`else
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_LIMIT);
    logic [7:0] scnt_q, scnt_d;

    // scnt counts cycles the DMA spends waiting behind the CPU; at the limit the DMA wins.
    always_comb begin
        grant_dma = dma_req & (~cpu_req | (scnt_q >= STARVE_LIM));
        scnt_d    = scnt_q;
        if (!dma_req || (in_idle && grant_dma)) begin
            scnt_d = 8'd0;
        end else if (!(!in_idle && owner_q == OWN_DMA) && scnt_q != 8'hFF) begin
            scnt_d = scnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scnt_q <= 8'd0;
        end else begin
            scnt_q <= scnt_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        wcnt_d      = wcnt_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req || dma_req) begin
                    owner_d = grant_dma;
                    addr_d  = grant_dma ? dma_addr  : cpu_addr;
                    we_d    = grant_dma ? dma_we    : cpu_we;
                    wdata_d = grant_dma ? dma_wdata : cpu_wdata;
                    wcnt_d  = WAIT_LOAD;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (wcnt_q == 4'd0) begin
                    if (!we_q) begin
                        if (owner_q == OWN_DMA) begin
                            dma_rdata_d = sram_din;
                        end else begin
                            cpu_rdata_d = sram_din;
                        end
                    end
                    state_d = ST_DONE;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_CPU;
            addr_q      <= 16'd0;
            we_q        <= 1'b0;
            wdata_q     <= 8'd0;
            wcnt_q      <= 4'd0;
            cpu_rdata_q <= 8'd0;
            dma_rdata_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            wcnt_q      <= wcnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    // Write data stays driven through DONE to give the SRAM hold time after WE falls.
    assign sram_addr = addr_q;
    assign sram_dout = wdata_q;
    assign sram_we   = in_access & we_q;
    assign sram_oe   = (in_access | in_done) & we_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign cpu_rdy   = ~cpu_req | (in_done & (owner_q == OWN_CPU));
    assign dma_ack   = in_done & (owner_q == OWN_DMA);

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: table of single transactions plus
// hand-written tie, starvation and mid-access reset sequences (WAIT_STATES=1).
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [15:0] cpu_addr, dma_addr;
    logic [7:0]  cpu_wdata, dma_wdata;
    logic [7:0]  cpu_rdata, dma_rdata;
    logic        cpu_rdy, dma_ack;
    logic [15:0] sram_addr;
    logic [7:0]  sram_dout, sram_din;
    logic        sram_oe, sram_we;

    logic [7:0]  mem [0:65535];

    int n_compares = 0;
    int n_miscompares = 0;

    int       got_lat, got_we, got_rdylow;
    logic [7:0] got_rdata;

    typedef struct {
        bit          is_dma;
        bit          we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rdata;
        int          exp_lat;
        int          exp_we;
        int          exp_rdylow;
    } vec_t;

    vec_t vecs [0:6];

    sram_arbiter #(.WAIT_STATES(1), .STARVE_LIMIT(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_rdy(cpu_rdy),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_din(sram_din),
        .sram_oe(sram_oe), .sram_we(sram_we)
    );

    always #5 clk = ~clk;

    // Async SRAM model: combinational read, write while the strobe is high.
    assign sram_din = mem[sram_addr];
    always @(posedge clk) begin
        if (sram_we) mem[sram_addr] <= sram_dout;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compares++;
        if (act !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bit done;
        @(negedge clk);
        if (v.is_dma) begin
            dma_req = 1'b1; dma_we = v.we; dma_addr = v.addr; dma_wdata = v.wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
        end
        #1;
        got_rdylow = cpu_rdy ? 0 : 1;
        got_we = 0;
        got_lat = 0;
        got_rdata = 8'h00;
        done = 1'b0;
        for (int k = 1; k <= 20 && !done; k++) begin
            @(negedge clk);
            if (sram_we) got_we++;
            if (v.is_dma ? dma_ack : cpu_rdy) begin
                got_lat = k;
                got_rdata = v.is_dma ? dma_rdata : cpu_rdata;
                done = 1'b1;
            end else if (!cpu_rdy) begin
                got_rdylow++;
            end
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
    endtask

    initial begin
        mem[16'h0F00] <= 8'h3C;
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 16'h0; dma_wdata = 8'h0;

        vecs[0] = '{1'b0, 1'b1, 16'h0123, 8'hA5, 8'h00, 3, 2, 3};
        vecs[1] = '{1'b0, 1'b0, 16'h0123, 8'h00, 8'hA5, 3, 0, 3};
        vecs[2] = '{1'b1, 1'b0, 16'h0F00, 8'h00, 8'h3C, 3, 0, 0};
        vecs[3] = '{1'b1, 1'b1, 16'h0200, 8'h5A, 8'h00, 3, 2, 0};
        vecs[4] = '{1'b0, 1'b0, 16'h0200, 8'h00, 8'h5A, 3, 0, 3};
        vecs[5] = '{1'b0, 1'b1, 16'h0FFF, 8'hFF, 8'h00, 3, 2, 3};
        vecs[6] = '{1'b1, 1'b0, 16'h0FFF, 8'h00, 8'hFF, 3, 0, 0};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_sram_we", 32'(sram_we), 32'd0);
        checkOutput("reset_sram_oe", 32'(sram_oe), 32'd0);
        checkOutput("reset_dma_ack", 32'(dma_ack), 32'd0);
        checkOutput("reset_cpu_rdy", 32'(cpu_rdy), 32'd1);
        checkOutput("reset_sram_addr", 32'(sram_addr), 32'd0);
        checkOutput("reset_cpu_rdata", 32'(cpu_rdata), 32'd0);
        checkOutput("reset_dma_rdata", 32'(dma_rdata), 32'd0);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d_latency", i), 32'(got_lat), 32'(vecs[i].exp_lat));
            checkOutput($sformatf("v%0d_we_cycles", i), 32'(got_we), 32'(vecs[i].exp_we));
            checkOutput($sformatf("v%0d_rdy_low", i), 32'(got_rdylow), 32'(vecs[i].exp_rdylow));
            if (!vecs[i].we)
                checkOutput($sformatf("v%0d_rdata", i), 32'(got_rdata), 32'(vecs[i].exp_rdata));
            @(negedge clk);
            checkOutput($sformatf("v%0d_ack_single", i), 32'(dma_ack), 32'd0);
            checkOutput($sformatf("v%0d_idle_oe", i), 32'(sram_oe), 32'd0);
            checkOutput($sformatf("v%0d_idle_addr", i), 32'(sram_addr), 32'(vecs[i].addr));
        end

        // Tie: CPU first (DONE at 3), DMA granted in the following IDLE (DONE at 7).
        begin
            int cpu_k, dma_k;
            logic [7:0] c_data, d_data;
            cpu_k = 0; dma_k = 0; c_data = 8'h00; d_data = 8'h00;
            @(negedge clk);
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0123;
            dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0F00;
            for (int k = 1; k <= 12; k++) begin
                @(negedge clk);
                if (cpu_req && cpu_rdy) begin cpu_k = k; c_data = cpu_rdata; cpu_req = 1'b0; end
                if (dma_req && dma_ack) begin dma_k = k; d_data = dma_rdata; dma_req = 1'b0; end
            end
            cpu_req = 1'b0; dma_req = 1'b0;
            checkOutput("tie_cpu_done", 32'(cpu_k), 32'd3);
            checkOutput("tie_dma_done", 32'(dma_k), 32'd7);
            checkOutput("tie_cpu_rdata", 32'(c_data), 32'hA5);
            checkOutput("tie_dma_rdata", 32'(d_data), 32'h3C);
        end

        // Both held: fixed priority lets the DMA through every third grant once scnt hits 8.
        begin
            int comp_k [$];
            bit comp_own [$];
            bit exp_own;
            @(negedge clk);
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0123;
            dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0F00;
            for (int k = 1; k <= 24; k++) begin
                @(negedge clk);
                if (cpu_rdy) begin comp_k.push_back(k); comp_own.push_back(1'b0); end
                if (dma_ack) begin comp_k.push_back(k); comp_own.push_back(1'b1); end
            end
            cpu_req = 1'b0; dma_req = 1'b0;
            checkOutput("starve_grants", 32'(comp_k.size()), 32'd6);
            for (int i = 0; i < 6; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
                exp_own = (i % 2) == 1;
`else
                exp_own = (i % 3) == 2;
`endif
                checkOutput($sformatf("starve_k%0d", i),
                            (i < comp_k.size()) ? 32'(comp_k[i]) : 32'hFFFFFFFF, 32'(3 + 4 * i));
                checkOutput($sformatf("starve_owner%0d", i),
                            (i < comp_own.size()) ? 32'(comp_own[i]) : 32'hFFFFFFFF, 32'(exp_own));
            end
        end

        // Reset during the second ACCESS cycle of a DMA write aborts with no ack.
        begin
            int acks;
            acks = 0;
            @(negedge clk);
            dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0300; dma_wdata = 8'h77;
            @(negedge clk);
            checkOutput("rst_access1_we", 32'(sram_we), 32'd1);
            @(negedge clk);
            checkOutput("rst_access2_we", 32'(sram_we), 32'd1);
            reset = 1'b1;
            dma_req = 1'b0;
            @(negedge clk);
            reset = 1'b0;
            checkOutput("rst_abort_we", 32'(sram_we), 32'd0);
            checkOutput("rst_abort_oe", 32'(sram_oe), 32'd0);
            for (int k = 0; k < 4; k++) begin
                if (dma_ack) acks++;
                @(negedge clk);
            end
            checkOutput("rst_no_ack", 32'(acks), 32'd0);
        end

        applyStimulus('{1'b0, 1'b0, 16'h0123, 8'h00, 8'hA5, 3, 0, 3});
        checkOutput("post_rst_latency", 32'(got_lat), 32'd3);
        checkOutput("post_rst_rdata", 32'(got_rdata), 32'hA5);

        $display("== %0d vectors applied, %0d miscompares ==", n_compares, n_miscompares);
        $finish;
    end

endmodule
